// File: rtl/gray_bin_conv_pkg.sv
`default_nettype none
// ============================================================================
// Module      : gray_bin_conv_pkg
// Description : Shared mode encodings and bitwise Gray/binary helper functions
//               used by the Gray/binary converter and its unit-distance monitor.
// Revision    : 1.0 - initial release
// ============================================================================
package gray_bin_conv_pkg;

    // Conversion mode encodings carried on the mode input.
    localparam logic MODE_G2B = 1'b0;
    localparam logic MODE_B2G = 1'b1;

    // Widest word the helpers handle; callers zero-extend narrower words.
    localparam int unsigned MAX_WIDTH = 32;

    // Mask with the low 'width' bits set.
    function automatic logic [MAX_WIDTH-1:0] width_mask(input int unsigned width);
        if (width >= MAX_WIDTH) begin
            return '1;
        end
        return (32'd1 << width) - 32'd1;
    endfunction

    // Gray to binary: each binary bit is the XOR of all Gray bits at or above it.
    // Bits above 'width' are masked to zero so they do not disturb the prefix XOR.
    function automatic logic [MAX_WIDTH-1:0] gray2bin(input logic [MAX_WIDTH-1:0] gv,
                                                      input int unsigned width);
        logic [MAX_WIDTH-1:0] gm;
        logic [MAX_WIDTH-1:0] bv;
        gm = gv & width_mask(width);
        bv = '0;
        bv[MAX_WIDTH-1] = gm[MAX_WIDTH-1];
        for (int i = MAX_WIDTH - 2; i >= 0; i--) begin
            bv[i] = bv[i+1] ^ gm[i];
        end
        return bv;
    endfunction

    // Binary to Gray: each bit XORed with its upper neighbour.
    function automatic logic [MAX_WIDTH-1:0] bin2gray(input logic [MAX_WIDTH-1:0] bv,
                                                      input int unsigned width);
        logic [MAX_WIDTH-1:0] bm;
        bm = bv & width_mask(width);
        return bm ^ (bm >> 1);
    endfunction

    // Number of set bits; six bits hold the full 0..32 range.
    function automatic logic [5:0] popcount(input logic [MAX_WIDTH-1:0] v);
        logic [5:0] cnt;
        cnt = '0;
        for (int i = 0; i < MAX_WIDTH; i++) begin
            cnt = cnt + {5'd0, v[i]};
        end
        return cnt;
    endfunction

endpackage : gray_bin_conv_pkg
`default_nettype wire

// File: rtl/gray_bin_conv_step_mon.sv
`default_nettype none
// ============================================================================
// Module      : gray_step_mon
// Description : Unit-distance monitor for a stream of Gray-coded words. Keeps
//               the last sampled word and flags any new word whose Hamming
//               distance from it is not exactly one.
// Revision    : 1.0 - initial release
// ============================================================================
module gray_step_mon
    import gray_bin_conv_pkg::*;
#(
    parameter int WIDTH = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             sample,
    input  logic [WIDTH-1:0] g,
    output logic             step_bad
);

    logic [WIDTH-1:0]     r_prev;
    logic                 r_have_prev;
    logic [WIDTH-1:0]     w_diff;
    logic [MAX_WIDTH-1:0] w_diff_ext;

    assign w_diff = g ^ r_prev;

    generate
        if (WIDTH < MAX_WIDTH) begin : g_diff_pad
            assign w_diff_ext = {{(MAX_WIDTH-WIDTH){1'b0}}, w_diff};
        end else begin : g_diff_full
            assign w_diff_ext = w_diff;
        end
    endgenerate

    // A repeat (distance 0) is as wrong as a multi-bit jump; the first word has nothing to compare with.
    assign step_bad = sample && r_have_prev && (popcount(w_diff_ext) != 6'd1);

    // Remember the latest sampled word; reset forgets it so the next word is exempt.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_prev      <= '0;
            r_have_prev <= 1'b0;
        end else if (sample) begin
            r_prev      <= g;
            r_have_prev <= 1'b1;
        end
    end

endmodule : gray_step_mon
`default_nettype wire

// File: rtl/gray_bin_conv.sv
`default_nettype none
// ============================================================================
// Module      : gray_bin_conv
// Description : Registered Gray-to-binary / binary-to-Gray converter with a
//               one-cycle valid pipeline and a unit-distance monitor on the
//               Gray-to-binary path.
// Revision    : 1.0 - initial release
// ============================================================================
module gray_bin_conv
    import gray_bin_conv_pkg::*;
#(
    parameter int WIDTH = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic             mode,
    input  logic [WIDTH-1:0] g,
    output logic [WIDTH-1:0] b,
    output logic             out_valid,
    output logic             step_err
);

    logic [MAX_WIDTH-1:0] w_g_ext;
    logic [MAX_WIDTH-1:0] w_conv_ext;
    logic [WIDTH-1:0]     w_conv;
    logic                 w_mon_sample;
    logic                 w_step_bad;

    logic [WIDTH-1:0]     r_b;
    logic                 r_out_valid;
    logic                 r_step_err;

    // Widen the input to the helper width; the upper result bits are always zero.
    generate
        if (WIDTH < MAX_WIDTH) begin : g_ext_pad
            logic w_unused_hi;
            assign w_g_ext     = {{(MAX_WIDTH-WIDTH){1'b0}}, g};
            assign w_unused_hi = ^w_conv_ext[MAX_WIDTH-1:WIDTH];
        end else begin : g_ext_full
            assign w_g_ext = g;
        end
    endgenerate

    assign w_conv_ext = (mode == MODE_B2G) ? bin2gray(w_g_ext, WIDTH)
                                           : gray2bin(w_g_ext, WIDTH);
    assign w_conv     = w_conv_ext[WIDTH-1:0];

    // Only valid Gray-to-binary words feed the monitor; binary-mode words leave its history untouched.
    assign w_mon_sample = in_valid && (mode == MODE_G2B);

    gray_step_mon #(
        .WIDTH (WIDTH)
    ) u_step_mon (
        .clk      (clk),
        .rst      (rst),
        .sample   (w_mon_sample),
        .g        (g),
        .step_bad (w_step_bad)
    );

    // Output stage: capture a result on valid words, hold b otherwise; step flag only on valid cycles.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_b         <= '0;
            r_out_valid <= 1'b0;
            r_step_err  <= 1'b0;
        end else begin
            r_out_valid <= in_valid;
            r_step_err  <= w_step_bad;
            if (in_valid) begin
                r_b <= w_conv;
            end
        end
    end

    assign b         = r_b;
    assign out_valid = r_out_valid;
    assign step_err  = r_step_err;

endmodule : gray_bin_conv
`default_nettype wire

// File: tb/tb_gray_bin_conv.sv
`default_nettype none
// ============================================================================
// Module      : tb_gray_bin_conv
// Description : Self-checking bench for gray_bin_conv at WIDTH 3 and WIDTH 8.
//               Directed cases plus random traffic against a search-based
//               reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_gray_bin_conv;

    logic       clk = 1'b0;
    logic       rst;
    logic       v3, m3;
    logic [2:0] g3, b3;
    logic       ov3, se3;
    logic       v8, m8;
    logic [7:0] g8, b8;
    logic       ov8, se8;

    int n_vec     = 0;
    int n_miscmp  = 0;

    // Reference model state, index 0 = WIDTH 3 instance, 1 = WIDTH 8 instance.
    logic [31:0] mdl_b    [2];
    logic [31:0] mdl_prev [2];
    bit          mdl_ov   [2];
    bit          mdl_se   [2];
    bit          mdl_have [2];

    always #5 clk = ~clk;

    gray_bin_conv #(.WIDTH(3)) dut3 (
        .clk(clk), .rst(rst), .in_valid(v3), .mode(m3), .g(g3),
        .b(b3), .out_valid(ov3), .step_err(se3)
    );

    gray_bin_conv #(.WIDTH(8)) dut8 (
        .clk(clk), .rst(rst), .in_valid(v8), .mode(m8), .g(g8),
        .b(b8), .out_valid(ov8), .step_err(se8)
    );

    // Gray-to-binary by search: the binary value n whose Gray code equals gv.
    function automatic logic [31:0] ref_g2b(input int w, input logic [31:0] gv);
        for (int n = 0; n < (1 << w); n++) begin
            if (32'(n ^ (n >> 1)) == gv) return 32'(n);
        end
        return 32'hDEAD_BEEF;
    endfunction

    function automatic logic [31:0] ref_b2g(input logic [31:0] bv);
        return bv ^ (bv >> 1);
    endfunction

    task automatic model(input int k, input int w, input bit r, input bit v,
                         input bit m, input logic [31:0] gv);
        if (r) begin
            mdl_b[k] = 0; mdl_ov[k] = 0; mdl_se[k] = 0;
            mdl_have[k] = 0; mdl_prev[k] = 0;
        end else begin
            mdl_ov[k] = v;
            mdl_se[k] = 0;
            if (v) begin
                if (m) begin
                    mdl_b[k] = ref_b2g(gv);
                end else begin
                    mdl_b[k]    = ref_g2b(w, gv);
                    mdl_se[k]   = mdl_have[k] && ($countones(gv ^ mdl_prev[k]) != 1);
                    mdl_have[k] = 1;
                    mdl_prev[k] = gv;
                end
            end
        end
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_miscmp++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // One clock: drive both instances, advance the model, sample 1 time unit after the edge.
    task automatic step(input bit r, input bit va, input bit ma, input logic [2:0] ga,
                        input bit vb, input bit mb, input logic [7:0] gb);
        rst = r; v3 = va; m3 = ma; g3 = ga; v8 = vb; m8 = mb; g8 = gb;
        model(0, 3, r, va, ma, 32'(ga));
        model(1, 8, r, vb, mb, 32'(gb));
        @(posedge clk);
        #1;
        check("b3",  32'(b3),  mdl_b[0]);
        check("ov3", 32'(ov3), 32'(mdl_ov[0]));
        check("se3", 32'(se3), 32'(mdl_se[0]));
        check("b8",  32'(b8),  mdl_b[1]);
        check("ov8", 32'(ov8), 32'(mdl_ov[1]));
        check("se8", 32'(se8), 32'(mdl_se[1]));
    endtask

    task automatic s3(input bit va, input bit ma, input logic [2:0] ga);
        step(1'b0, va, ma, ga, 1'b0, 1'b0, 8'h00);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [2:0] sweep_exp [8];
        logic [2:0] gray_seq  [9];
        logic [2:0] rg3;
        logic [7:0] rg8;
        bit rr, rva, rma, rvb, rmb;

        sweep_exp = '{3'd0, 3'd1, 3'd3, 3'd2, 3'd7, 3'd6, 3'd4, 3'd5};
        gray_seq  = '{3'b000, 3'b001, 3'b011, 3'b010, 3'b110,
                      3'b111, 3'b101, 3'b100, 3'b000};
        rst = 1'b1; v3 = 0; m3 = 0; g3 = 0; v8 = 0; m8 = 0; g8 = 0;

        // Reset state, with a valid word presented during reset that must be dropped.
        step(1'b1, 1'b1, 1'b0, 3'b101, 1'b1, 1'b0, 8'h5A);
        step(1'b1, 1'b0, 1'b0, 3'b000, 1'b0, 1'b0, 8'h00);
        check("rst_b",  32'(b3),  32'd0);
        check("rst_ov", 32'(ov3), 32'd0);
        check("rst_se", 32'(se3), 32'd0);

        // Counting sweep treated as Gray input.
        for (int i = 0; i < 8; i++) begin
            s3(1'b1, 1'b0, 3'(i));
            check("sweep_b",  32'(b3),  32'(sweep_exp[i]));
            check("sweep_ov", 32'(ov3), 32'd1);
            if (i == 2) check("sweep_se_1to2", 32'(se3), 32'd1);
        end

        // True Gray count including wrap-around.
        step(1'b1, 1'b0, 1'b0, 3'b000, 1'b0, 1'b0, 8'h00);
        for (int i = 0; i < 9; i++) begin
            s3(1'b1, 1'b0, gray_seq[i]);
            check("gray_b",  32'(b3),  32'(i % 8));
            check("gray_se", 32'(se3), 32'd0);
        end

        // Binary-to-Gray mode.
        s3(1'b1, 1'b1, 3'b101);
        check("b2g_101", 32'(b3),  32'b111);
        check("b2g_se",  32'(se3), 32'd0);
        s3(1'b1, 1'b1, 3'b110);
        check("b2g_110", 32'(b3),  32'b101);
        check("b2g_se",  32'(se3), 32'd0);

        // Hold while in_valid is low.
        s3(1'b1, 1'b0, 3'b111);
        check("hold_src", 32'(b3), 32'b101);
        for (int i = 0; i < 3; i++) begin
            s3(1'b0, 1'b0, 3'(i));
            check("hold_b",  32'(b3),  32'b101);
            check("hold_ov", 32'(ov3), 32'd0);
        end

        // Repeated value flags; reset re-arms the first-word exemption.
        s3(1'b1, 1'b0, 3'b011);
        s3(1'b1, 1'b0, 3'b011);
        check("repeat_se", 32'(se3), 32'd1);
        step(1'b1, 1'b0, 1'b0, 3'b000, 1'b0, 1'b0, 8'h00);
        s3(1'b1, 1'b0, 3'b110);
        check("post_rst_b",  32'(b3),  32'b100);
        check("post_rst_se", 32'(se3), 32'd0);

        // Wider instance boundary values.
        step(1'b0, 1'b0, 1'b0, 3'b000, 1'b1, 1'b0, 8'h80);
        check("w8_80", 32'(b8), 32'hFF);
        step(1'b0, 1'b0, 1'b0, 3'b000, 1'b1, 1'b0, 8'hFF);
        check("w8_FF", 32'(b8), 32'hAA);

        // Random traffic, biased toward single-bit Gray steps so both step_err outcomes occur.
        for (int i = 0; i < 400; i++) begin
            rr  = ($urandom_range(0, 49) == 0);
            rva = ($urandom_range(0, 3) != 0);
            rma = ($urandom_range(0, 3) == 0);
            rvb = ($urandom_range(0, 3) != 0);
            rmb = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 2) != 0)
                rg3 = mdl_prev[0][2:0] ^ 3'(1 << $urandom_range(0, 2));
            else
                rg3 = 3'($urandom);
            if ($urandom_range(0, 2) != 0)
                rg8 = mdl_prev[1][7:0] ^ 8'(1 << $urandom_range(0, 7));
            else
                rg8 = 8'($urandom);
            step(rr, rva, rma, rg3, rvb, rmb, rg8);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miscmp);
        $finish;
    end

endmodule : tb_gray_bin_conv
`default_nettype wire
